// File: rtl/ds_scfifo_ext.sv
// ds_scfifo_ext -- single-clock DataStream FIFO on inferred RAM.
//
// Buffers up to DEPTH words between a stream producer and a stream
// consumer. DEPTH may be any integer >= 2. The pointers wrap explicitly at
// DEPTH-1. The head word is held in a registered show-ahead stage in front
// of the RAM, so o_dat never comes combinationally from i_dat.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset (synchronous release)
//   clear        synchronous flush, active-high; discards any coincident
//                write/read
//   i_dat/i_val/i_rdy   inbound stream (i_rdy = not full)
//   o_dat/o_val/o_rdy   outbound stream, show-ahead head word
//   used         words currently stored (0..DEPTH)
//   almost_full  registered, used >= AFULL
//   almost_empty registered, used <= AEMPTY
module ds_scfifo_ext #(
    parameter int    DWIDTH  = 8,
    parameter int    DEPTH   = 8,
    parameter int    AFULL   = DEPTH - 1,
    parameter int    AEMPTY  = 1,
    parameter string RAMTYPE = "AUTO"
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic [DWIDTH-1:0]            i_dat,
    input  logic                         i_val,
    output logic                         i_rdy,
    output logic [DWIDTH-1:0]            o_dat,
    output logic                         o_val,
    input  logic                         o_rdy,
    output logic [$clog2(DEPTH+1)-1:0]   used,
    output logic                         almost_full,
    output logic                         almost_empty
);

    localparam int             PW       = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int             UW       = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]  PTR_LAST = PW'(DEPTH - 1);
    localparam logic [UW-1:0]  CNT_FULL = UW'(DEPTH);
    localparam logic [UW-1:0]  AF_LVL   = UW'(AFULL);
    localparam logic [UW-1:0]  AE_LVL   = UW'(AEMPTY);

    // Reject unknown RAM block hints at elaboration time.
    if (RAMTYPE != "AUTO" && RAMTYPE != "MLAB" && RAMTYPE != "M20K") begin : g_bad_ramtype
        $error("ds_scfifo_ext: unsupported RAMTYPE");
    end

    (* ramstyle = RAMTYPE *) logic [DWIDTH-1:0] r_mem [DEPTH];

    logic [PW-1:0]     r_wrptr;
    logic [PW-1:0]     r_rdptr;
    logic [UW-1:0]     r_used;
    logic              r_oval;
    logic              r_afull;
    logic              r_aempty;
    logic [DWIDTH-1:0] r_odat;

    logic              w_wr;
    logic              w_rd;
    logic              w_load;
    logic [UW-1:0]     w_ram_cnt;
    logic [UW-1:0]     w_used_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Full refuses a write even when a read happens in the same cycle, so
    // i_rdy does not depend on o_rdy.
    assign i_rdy = (r_used != CNT_FULL);
    assign w_wr  = i_val & i_rdy & ~clear;
    assign w_rd  = r_oval & o_rdy & ~clear;

    // Words still in the RAM (those not yet moved to the head register).
    assign w_ram_cnt = r_used - UW'(r_oval);

    // Refill the head register whenever it is empty or being consumed and
    // the RAM holds a word written at an earlier edge. The RAM is only read
    // at r_rdptr while it holds at least one word, and it can then only
    // coincide with r_wrptr when all DEPTH words sit in the RAM -- in which
    // case writes are refused. The RAM's read-during-write mode therefore
    // never matters.
    assign w_load = ~clear & (w_ram_cnt != '0) & (~r_oval | o_rdy);

    always_comb begin
        w_used_nxt = r_used;
        if (clear)
            w_used_nxt = '0;
        else if (w_wr && !w_rd)
            w_used_nxt = r_used + 1'b1;
        else if (!w_wr && w_rd)
            w_used_nxt = r_used - 1'b1;
    end

    // Control state: pointers, occupancy, head-valid and flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrptr  <= '0;
            r_rdptr  <= '0;
            r_used   <= '0;
            r_oval   <= 1'b0;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            r_used   <= w_used_nxt;
            r_afull  <= (w_used_nxt >= AF_LVL);
            r_aempty <= (w_used_nxt <= AE_LVL);
            if (clear) begin
                r_wrptr <= '0;
                r_rdptr <= '0;
                r_oval  <= 1'b0;
            end else begin
                if (w_wr)
                    r_wrptr <= ptr_inc(r_wrptr);
                if (w_load)
                    r_rdptr <= ptr_inc(r_rdptr);
                if (w_load)
                    r_oval <= 1'b1;
                else if (w_rd)
                    r_oval <= 1'b0;
            end
        end
    end

    // Storage and head data register: no reset, contents are don't-care
    // until qualified by o_val.
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wrptr] <= i_dat;
        if (w_load)
            r_odat <= r_mem[r_rdptr];
    end

    assign o_dat        = r_odat;
    assign o_val        = r_oval;
    assign used         = r_used;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;

endmodule

// File: tb/tb_ds_scfifo_ext.sv
module tb_ds_scfifo_ext;

    localparam int DW     = 8;
    localparam int DEPTH  = 5;
    localparam int AFULL  = DEPTH - 1;
    localparam int AEMPTY = 1;
    localparam int UW     = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic [DW-1:0] i_dat = '0;
    logic          i_val = 1'b0;
    logic          i_rdy;
    logic [DW-1:0] o_dat;
    logic          o_val;
    logic          o_rdy = 1'b0;
    logic [UW-1:0] used;
    logic          almost_full;
    logic          almost_empty;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of stored words, each tagged with the edge
    // number at which it was written. A word becomes visible at the head
    // one edge after it was written.
    typedef struct {
        logic [DW-1:0] d;
        int unsigned   t;
    } ent_t;

    ent_t        q[$];
    int unsigned edge_n = 0;

    ds_scfifo_ext #(
        .DWIDTH (DW),
        .DEPTH  (DEPTH),
        .AFULL  (AFULL),
        .AEMPTY (AEMPTY),
        .RAMTYPE("AUTO")
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .i_dat       (i_dat),
        .i_val       (i_val),
        .i_rdy       (i_rdy),
        .o_dat       (o_dat),
        .o_val       (o_val),
        .o_rdy       (o_rdy),
        .used        (used),
        .almost_full (almost_full),
        .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_oval();
        return (q.size() > 0) && (q[0].t < edge_n);
    endfunction

    task automatic check_outputs();
        int n;
        n = q.size();
        chk("used", 32'(used), 32'(n));
        chk("o_val", 32'(o_val), 32'(model_oval()));
        chk("i_rdy", 32'(i_rdy), 32'(n != DEPTH));
        chk("almost_full", 32'(almost_full), 32'(n >= AFULL));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AEMPTY));
        if (model_oval())
            chk("o_dat", 32'(o_dat), 32'(q[0].d));
    endtask

    // Called just after a falling edge: drive inputs, take one rising edge,
    // update the model, then check at the next falling edge.
    task automatic cycle(input bit v, input bit r, input bit c, input logic [DW-1:0] d);
        bit   wr;
        bit   rd;
        ent_t e;
        i_val = v;
        o_rdy = r;
        clear = c;
        i_dat = d;
        wr = v && (q.size() != DEPTH) && !c;
        rd = model_oval() && r && !c;
        @(posedge clk);
        edge_n++;
        if (c) begin
            q.delete();
        end else begin
            if (rd)
                void'(q.pop_front());
            if (wr) begin
                e.d = d;
                e.t = edge_n;
                q.push_back(e);
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        // Reset state, checked while reset is held.
        repeat (3) @(negedge clk);
        chk("rst_used", 32'(used), 32'd0);
        chk("rst_o_val", 32'(o_val), 32'd0);
        chk("rst_i_rdy", 32'(i_rdy), 32'd1);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_outputs();

        // Fill with the consumer stalled (two extra refused writes), then drain.
        for (int i = 1; i <= DEPTH + 2; i++)
            cycle(1'b1, 1'b0, 1'b0, DW'(i));
        for (int i = 0; i < DEPTH + 2; i++)
            cycle(1'b0, 1'b1, 1'b0, '0);

        // Continuous stream through the non-power-of-two depth.
        for (int i = 0; i < 23; i++)
            cycle(i < 20, 1'b1, 1'b0, DW'(8'h20 + i));

        // Full with simultaneous read: write refused, used drops by one.
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 1'b0, 1'b0, DW'(8'h40 + i));
        cycle(1'b1, 1'b1, 1'b0, 8'hEE);
        cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, 8'h55);
        for (int i = 0; i < DEPTH + 1; i++)
            cycle(1'b0, 1'b1, 1'b0, '0);

        // Clear with coincident write and read.
        for (int i = 0; i < DEPTH - 1; i++)
            cycle(1'b1, 1'b0, 1'b0, DW'(8'h60 + i));
        cycle(1'b1, 1'b1, 1'b1, 8'hCC);
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, 8'h77);
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);

        // Asynchronous reset between edges while holding three words.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b0, 1'b0, DW'(8'h90 + i));
        i_val = 1'b0;
        o_rdy = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_used", 32'(used), 32'd0);
        chk("arst_o_val", 32'(o_val), 32'd0);
        chk("arst_i_rdy", 32'(i_rdy), 32'd1);
        chk("arst_afull", 32'(almost_full), 32'd0);
        chk("arst_aempty", 32'(almost_empty), 32'd1);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_outputs();
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b1, 1'b0, DW'(8'hA0 + i));
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b0, 1'b1, 1'b0, '0);

        // Random traffic at several producer/consumer duty ratios, with
        // occasional flushes.
        for (int p = 0; p < 3; p++) begin
            int pv;
            int pr;
            pv = (p == 0) ? 30 : (p == 1) ? 70 : 50;
            pr = (p == 0) ? 70 : (p == 1) ? 30 : 50;
            for (int i = 0; i < 1500; i++)
                cycle($urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr,
                      $urandom_range(0, 199) == 0, DW'($urandom));
        end
        for (int i = 0; i < DEPTH + 2; i++)
            cycle(1'b0, 1'b1, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
